// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// default latencies and the control state encoding.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDOP_NONE  = 3'd0,
        MDOP_MULT  = 3'd1,
        MDOP_MULTU = 3'd2,
        MDOP_DIV   = 3'd3,
        MDOP_DIVU  = 3'd4,
        MDOP_MTHI  = 3'd5,
        MDOP_MTLO  = 3'd6,
        MDOP_RSVD  = 3'd7
    } mdop_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX-stage control and the multiply/divide unit.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        Start_In;
    logic [2:0]  Mdop_In;
    logic [31:0] SrcA_In;
    logic [31:0] SrcB_In;
    logic        Md_Req_In;
    logic        Busy_Out;
    logic        Stall_Out;
    logic [31:0] Hi_Out;
    logic [31:0] Lo_Out;

    modport master (
        output Start_In, Mdop_In, SrcA_In, SrcB_In, Md_Req_In,
        input  Busy_Out, Stall_Out, Hi_Out, Lo_Out
    );

    modport slave (
        input  Start_In, Mdop_In, SrcA_In, SrcB_In, Md_Req_In,
        output Busy_Out, Stall_Out, Hi_Out, Lo_Out
    );

endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO. The result is computed at
// launch, staged in tmp_hi/tmp_lo, and committed when the countdown expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic           Clk_In,
    input  logic           Rst_N_In,
    mult_div_unit_if.slave bus
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;

    mdop_e              mdop;
    logic               div_by_zero;
    logic signed [63:0] src_a_sx, src_b_sx, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    assign mdop = mdop_e'(bus.Mdop_In);

    // A zero divisor is replaced by 1 so the divider never sees x/0; the
    // result is discarded in that case anyway.
    always_comb begin
        div_by_zero = (bus.SrcB_In == 32'd0);
        divisor     = div_by_zero ? 32'd1 : bus.SrcB_In;
        src_a_sx    = {{32{bus.SrcA_In[31]}}, bus.SrcA_In};
        src_b_sx    = {{32{bus.SrcB_In[31]}}, bus.SrcB_In};
        prod_s      = src_a_sx * src_b_sx;
        prod_u      = {32'd0, bus.SrcA_In} * {32'd0, bus.SrcB_In};
        quot_s      = $signed(bus.SrcA_In) / $signed(divisor);
        rem_s       = $signed(bus.SrcA_In) % $signed(divisor);
        quot_u      = bus.SrcA_In / divisor;
        rem_u       = bus.SrcA_In % divisor;
    end

    always_comb begin
        // NOTE: every signal is given its hold value first so that no branch
        // can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start_In) begin
                    case (mdop)
                        MDOP_MULT: begin
                            tmp_hi_d = prod_s[63:32];
                            tmp_lo_d = prod_s[31:0];
                            cnt_d    = MULT_CNT;
                            state_d  = ST_BUSY;
                        end
                        MDOP_MULTU: begin
                            tmp_hi_d = prod_u[63:32];
                            tmp_lo_d = prod_u[31:0];
                            cnt_d    = MULT_CNT;
                            state_d  = ST_BUSY;
                        end
                        MDOP_DIV: begin
                            // Divide by zero stages the current HI/LO so the commit is a no-op.
                            tmp_hi_d = div_by_zero ? hi_q : rem_s;
                            tmp_lo_d = div_by_zero ? lo_q : quot_s;
                            cnt_d    = DIV_CNT;
                            state_d  = ST_BUSY;
                        end
                        MDOP_DIVU: begin
                            tmp_hi_d = div_by_zero ? hi_q : rem_u;
                            tmp_lo_d = div_by_zero ? lo_q : quot_u;
                            cnt_d    = DIV_CNT;
                            state_d  = ST_BUSY;
                        end
                        MDOP_MTHI: hi_d = bus.SrcA_In;
                        MDOP_MTLO: lo_d = bus.SrcA_In;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk_In or negedge Rst_N_In) begin
        if (!Rst_N_In) begin
            // NOTE: the staging pair is reset too, so an aborted operation
            // leaves no stale result behind.
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    assign bus.Busy_Out  = (state_q == ST_BUSY);
    assign bus.Stall_Out = bus.Md_Req_In & (bus.Start_In | bus.Busy_Out);
    assign bus.Hi_Out    = hi_q;
    assign bus.Lo_Out    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a cycle-level behavioural model
// compared every cycle, plus hand-computed expectations per directed vector.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mult_div_unit_if md_bus ();

    mult_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .Clk_In   (clk),
        .Rst_N_In (rst_n),
        .bus      (md_bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: remaining busy cycles plus the pending HI/LO pair.
    int          m_rem = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;

    initial begin : model
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_rem = 0;
                m_hi  = '0;
                m_lo  = '0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end else if (md_bus.Start_In) begin
                sa = md_bus.SrcA_In;
                sb = md_bus.SrcB_In;
                case (md_bus.Mdop_In)
                    MDOP_MULT: begin
                        p     = longint'(sa) * longint'(sb);
                        m_phi = p[63:32];
                        m_plo = p[31:0];
                        m_rem = ML;
                    end
                    MDOP_MULTU: begin
                        pu    = {32'd0, md_bus.SrcA_In} * {32'd0, md_bus.SrcB_In};
                        m_phi = pu[63:32];
                        m_plo = pu[31:0];
                        m_rem = ML;
                    end
                    MDOP_DIV: begin
                        m_phi = (sb == 0) ? m_hi : 32'(sa % sb);
                        m_plo = (sb == 0) ? m_lo : 32'(sa / sb);
                        m_rem = DL;
                    end
                    MDOP_DIVU: begin
                        m_phi = (sb == 0) ? m_hi : md_bus.SrcA_In % md_bus.SrcB_In;
                        m_plo = (sb == 0) ? m_lo : md_bus.SrcA_In / md_bus.SrcB_In;
                        m_rem = DL;
                    end
                    MDOP_MTHI: m_hi = md_bus.SrcA_In;
                    MDOP_MTLO: m_lo = md_bus.SrcA_In;
                    default: ;
                endcase
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            #1;
            if (cmp_en) begin
                check("cyc_busy", md_bus.Busy_Out, m_rem > 0);
                check("cyc_hi", md_bus.Hi_Out, m_hi);
                check("cyc_lo", md_bus.Lo_Out, m_lo);
                check("cyc_stall", md_bus.Stall_Out,
                      md_bus.Md_Req_In & (md_bus.Start_In | (m_rem > 0)));
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n = 0;
        @(negedge clk);
        md_bus.Start_In = 1'b1;
        md_bus.Mdop_In  = op;
        md_bus.SrcA_In  = a;
        md_bus.SrcB_In  = b;
        #1 check({name, "_stall_start"}, md_bus.Stall_Out, md_bus.Md_Req_In);
        @(negedge clk);
        md_bus.Start_In = 1'b0;
        md_bus.Mdop_In  = MDOP_NONE;
        while (md_bus.Busy_Out === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        #1;
        check({name, "_lat"}, n, lat);
        check({name, "_hi"}, md_bus.Hi_Out, ehi);
        check({name, "_lo"}, md_bus.Lo_Out, elo);
        check({name, "_stall_idle"}, md_bus.Stall_Out, 1'b0);
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        md_bus.Start_In = 1'b1;
        md_bus.Mdop_In  = op;
        md_bus.SrcA_In  = a;
        @(negedge clk);
        md_bus.Start_In = 1'b0;
        md_bus.Mdop_In  = MDOP_NONE;
    endtask

    initial begin : main
        int n;
        md_bus.Start_In  = 1'b0;
        md_bus.Mdop_In   = MDOP_NONE;
        md_bus.SrcA_In   = '0;
        md_bus.SrcB_In   = '0;
        md_bus.Md_Req_In = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        #1;
        check("rst_busy", md_bus.Busy_Out, 1'b0);
        check("rst_hi", md_bus.Hi_Out, 32'h0);
        check("rst_lo", md_bus.Lo_Out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult",  MDOP_MULT,  32'hFFFF_FFFF, 32'h2, ML, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", MDOP_MULTU, 32'hFFFF_FFFF, 32'h2, ML, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult2", MDOP_MULT,  32'h7, 32'hFFFF_FFFD, ML, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div",   MDOP_DIV,   32'hFFFF_FFF9, 32'h2, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div2",  MDOP_DIV,   32'h7, 32'hFFFF_FFFE, DL, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu",  MDOP_DIVU,  32'h7, 32'h2, DL, 32'h1, 32'h3);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        md_bus.Start_In = 1'b1;
        md_bus.Mdop_In  = MDOP_MTHI;
        md_bus.SrcA_In  = 32'hDEAD_BEEF;
        @(negedge clk);
        md_bus.Mdop_In  = MDOP_MTLO;
        md_bus.SrcA_In  = 32'h1234_5678;
        #1;
        check("mthi_hi", md_bus.Hi_Out, 32'hDEAD_BEEF);
        check("mthi_busy", md_bus.Busy_Out, 1'b0);
        @(negedge clk);
        md_bus.Start_In = 1'b0;
        md_bus.Mdop_In  = MDOP_NONE;
        #1;
        check("mtlo_lo", md_bus.Lo_Out, 32'h1234_5678);
        check("mtlo_hi", md_bus.Hi_Out, 32'hDEAD_BEEF);
        check("mtlo_busy", md_bus.Busy_Out, 1'b0);

        write_hilo(MDOP_MTHI, 32'h1111_1111);
        write_hilo(MDOP_MTLO, 32'h2222_2222);
        run_op("div0", MDOP_DIV, 32'h5, 32'h0, DL, 32'h1111_1111, 32'h2222_2222);

        md_bus.Md_Req_In = 1'b1;
        run_op("stall_mult", MDOP_MULT, 32'h3, 32'h4, ML, 32'h0, 32'hC);
        md_bus.Md_Req_In = 1'b0;

        // divu launched at busy cycle 2 of a mult must be ignored
        n = 0;
        @(negedge clk);
        md_bus.Start_In = 1'b1;
        md_bus.Mdop_In  = MDOP_MULT;
        md_bus.SrcA_In  = 32'h6;
        md_bus.SrcB_In  = 32'h7;
        @(negedge clk);
        md_bus.Start_In = 1'b0;
        while (md_bus.Busy_Out === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                md_bus.Start_In = 1'b1;
                md_bus.Mdop_In  = MDOP_DIVU;
                md_bus.SrcA_In  = 32'd100;
                md_bus.SrcB_In  = 32'd7;
            end else begin
                md_bus.Start_In = 1'b0;
            end
            @(negedge clk);
        end
        md_bus.Start_In = 1'b0;
        md_bus.Mdop_In  = MDOP_NONE;
        #1;
        check("ign_lat", n, ML);
        check("ign_hi", md_bus.Hi_Out, 32'h0);
        check("ign_lo", md_bus.Lo_Out, 32'd42);

        // reset at busy cycle 3 of a mult
        @(negedge clk);
        md_bus.Start_In = 1'b1;
        md_bus.Mdop_In  = MDOP_MULT;
        md_bus.SrcA_In  = 32'h3;
        md_bus.SrcB_In  = 32'h5;
        @(negedge clk);
        md_bus.Start_In = 1'b0;
        md_bus.Mdop_In  = MDOP_NONE;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", md_bus.Busy_Out, 1'b0);
        check("abort_hi", md_bus.Hi_Out, 32'h0);
        check("abort_lo", md_bus.Lo_Out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("post_abort_busy", md_bus.Busy_Out, 1'b0);
        check("post_abort_hi", md_bus.Hi_Out, 32'h0);
        check("post_abort_lo", md_bus.Lo_Out, 32'h0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
